// File: rtl/kbd_matrix_scanner.sv
// ---------------------------------------------------------------------------
// kbd_matrix_scanner
//
// Scans a 4x4 mechanical key matrix and debounces presses. One row at a time
// is driven low. Its columns are sampled after a settle window. A candidate
// key is debounced before it is accepted, and its release is debounced before
// scanning resumes. Accepted keys are presented as a 4-bit code
// (row*4 + col) with a valid flag that is cleared by a read strobe. A sticky
// overflow flag marks keys that arrived while an unread code was pending.
//
// Handshake: key_valid rises when a key is accepted and stays high until
// key_ack is seen. key_ack is a single-cycle strobe. While key_valid is high,
// key_ack clears key_valid and key_overflow on the next edge. While key_valid
// is low, key_ack has no effect. If key_ack coincides with an accept, the new
// code is taken, key_valid stays high and key_overflow is cleared.
//
// Ports:
//   led_clk      in   scan clock (20 kHz)
//   rst          in   synchronous active-high reset
//   col_in[3:0]  in   matrix columns, active-low, asynchronous
//   key_ack      in   read strobe, led_clk domain
//   row_out[3:0] out  row drive, exactly one bit low
//   key_code[3:0]out  last accepted key
//   key_valid    out  key_code holds an unread key
//   key_overflow out  a key was accepted while key_valid was already set
//   key_down     out  an accepted key is still held
// ---------------------------------------------------------------------------
module kbd_matrix_scanner #(
  parameter int SETTLE   = 4,
  parameter int DEBOUNCE = 200
) (
  input  logic       led_clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  input  logic       key_ack,
  output logic [3:0] row_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_overflow,
  output logic       key_down
);

  localparam int SLOT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    ST_SCAN      = 2'd0,
    ST_DEB_PRESS = 2'd1,
    ST_HELD      = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        col_meta_q, col_meta_d;
  logic [3:0]        col_s_q, col_s_d;
  logic [1:0]        row_q, row_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        key_row_q, key_row_d;
  logic [1:0]        key_col_q, key_col_d;
  logic [3:0]        row_out_q, row_out_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_overflow_q, key_overflow_d;
  logic              key_down_q, key_down_d;

  logic       hit_any;
  logic [1:0] hit_col;
  logic       tracked_high;
  logic       accept;

  // Lowest-index low column wins: the loop runs downward so index 0 is the
  // last assignment to take effect.
  always_comb begin
    hit_any = (col_s_q != 4'hF);
    hit_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) hit_col = 2'(i);
    end
  end

  assign tracked_high = col_s_q[key_col_q];

  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    slot_d         = slot_q;
    cnt_d          = cnt_q;
    key_row_d      = key_row_q;
    key_col_d      = key_col_q;
    key_code_d     = key_code_q;
    key_valid_d    = key_valid_q;
    key_overflow_d = key_overflow_q;
    accept         = 1'b0;
    col_meta_d     = col_in;
    col_s_d        = col_meta_q;

    case (state_q)
      ST_SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          if (!hit_any) begin
            row_d = row_q + 2'd1;
          end else begin
            // Hold the row drive so the candidate column stays observable.
            key_row_d = row_q;
            key_col_d = hit_col;
            cnt_d     = '0;
            state_d   = ST_DEB_PRESS;
          end
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      ST_DEB_PRESS: begin
        if (tracked_high) begin
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
          slot_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = ST_HELD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!tracked_high) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_SCAN;
          row_d   = row_q + 2'd1;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_SCAN;
        row_d   = 2'd0;
        slot_d  = '0;
        cnt_d   = '0;
      end
    endcase

    if (key_ack && key_valid_q) begin
      key_valid_d    = 1'b0;
      key_overflow_d = 1'b0;
    end
    // An ack in the accept cycle frees the slot, so the new code is taken.
    if (accept) begin
      if (!key_valid_q || key_ack) begin
        key_code_d  = {key_row_q, key_col_q};
        key_valid_d = 1'b1;
      end else begin
        key_overflow_d = 1'b1;
      end
    end

    row_out_d  = ~(4'b0001 << row_d);
    key_down_d = (state_d == ST_HELD);
  end

  always_ff @(posedge led_clk) begin
    if (rst) begin
      state_q        <= ST_SCAN;
      col_meta_q     <= 4'hF;
      col_s_q        <= 4'hF;
      row_q          <= 2'd0;
      slot_q         <= '0;
      cnt_q          <= '0;
      key_row_q      <= 2'd0;
      key_col_q      <= 2'd0;
      row_out_q      <= 4'b1110;
      key_code_q     <= 4'd0;
      key_valid_q    <= 1'b0;
      key_overflow_q <= 1'b0;
      key_down_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_meta_q     <= col_meta_d;
      col_s_q        <= col_s_d;
      row_q          <= row_d;
      slot_q         <= slot_d;
      cnt_q          <= cnt_d;
      key_row_q      <= key_row_d;
      key_col_q      <= key_col_d;
      row_out_q      <= row_out_d;
      key_code_q     <= key_code_d;
      key_valid_q    <= key_valid_d;
      key_overflow_q <= key_overflow_d;
      key_down_q     <= key_down_d;
    end
  end

  assign row_out      = row_out_q;
  assign key_code     = key_code_q;
  assign key_valid    = key_valid_q;
  assign key_overflow = key_overflow_q;
  assign key_down     = key_down_q;

endmodule

// File: doc/kbd_matrix_scanner.md
# kbd_matrix_scanner

Scans a 4x4 mechanical key matrix with a one-hot active-low row drive and debounces presses. Each accepted press is delivered as a 4-bit key code with a valid/ack handshake and a sticky overflow flag. It is the input-side counterpart of the board's seven-segment anode scan and runs from the same 20 kHz led_clk. Its outputs are read by the CPU I/O logic alongside the PS/2 keyboard status.

## Interface
- SETTLE, 4: led_clk cycles each row is driven before its columns are sampled; must be ≥3.
- DEBOUNCE, 200: consecutive stable samples required to accept a press or a release; 200 cycles is 10 ms at 20 kHz.
- led_clk  input  1  scan clock, 20 kHz.
- rst  input  1  reset; synchronous, active-high, clocked by led_clk.
- col_in  input  4  matrix columns; active-low, externally pulled up, asynchronous.
- row_out  output  4  row drive; exactly one bit is low at all times.
- key_code  output  4  last accepted key, computed as row*4 + col.
- key_valid  output  1  key_code holds an unread key.
- key_overflow  output  1  a key was accepted while key_valid was already 1.
- key_down  output  1  level; high while an accepted key is still held.
- key_ack  input  1  single-cycle read strobe in the led_clk domain.

## Operation
- col_in passes through a 2-flop synchronizer. Only the synchronized value (col_s) is used internally.
- The slot counter counts 0..SETTLE-1 per row. Columns are sampled only when slot = SETTLE-1. The row index is 0..3 and wraps 3 -> 0.
- Column priority: if several col_s bits are low, the lowest index wins. Only the winning column is tracked afterward.
- State SCAN:
  - At a sample point with col_s = 4'hF, advance to the next row.
  - Otherwise capture row r and column c, clear the debounce counter, and go to DEB_PRESS. The row drive is held.
- State DEB_PRESS: sample col_s[c] every cycle.
  - If it is high, return to SCAN and advance to the next row. Nothing is reported.
  - When the counter reaches DEBOUNCE-1 with the bit still low, accept the key and go to HELD.
- Accept action:
  - If key_valid = 0, or key_ack is high in the same cycle: load key_code = {r,c} and set key_valid = 1.
  - Otherwise: key_code is unchanged and key_overflow is set to 1.
- State HELD: key_down = 1. Sample col_s[c] every cycle.
  - Any low sample clears the release counter.
  - DEBOUNCE consecutive high samples -> go to SCAN and advance to the next row.
  - Other keys are ignored while in HELD.
- Handshake:
  - key_ack clears key_valid and key_overflow on the next edge.
  - If key_ack arrives while key_valid = 0, it has no effect.
  - key_ack in the same cycle as an accept: the new code is loaded, key_valid stays 1, and key_overflow is cleared.
- Reset at any point, including mid-debounce, drops the key silently. Every state returns to its reset value.

## Timing
- Reset values:
  - row_out = 4'b1110, row index 0, slot 0, state SCAN.
  - key_code = 0, key_valid = 0, key_overflow = 0, key_down = 0.
  - Synchronizer flops = 4'hF, all counters 0.
- All outputs are registered and change only on the led_clk rising edge.
- Full frame = 4*SETTLE cycles (16 cycles = 800 µs at the defaults).
- Press latency, measured from the first low col_in edge to key_valid rising:
  - 2 synchronizer cycles, plus up to 4*SETTLE cycles waiting for the row's sample point, plus DEBOUNCE cycles.
  - Maximum 218 cycles at the defaults.
- key_down rises in the same cycle as the accept. It falls DEBOUNCE+2 cycles after col_in returns high.
- After a release, row_out advances one row in the same edge that key_down falls.
- A key is reported once per press. Auto-repeat does not exist.

## Test plan
- Reset check: after rst, row_out = 1110 and all outputs are 0. Row drive rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110 with 4 cycles per row and no press applied.
- Clean press of row 2, col 1 held 300 cycles -> key_valid rises with key_code = 9 and key_down = 1. Release -> key_down falls 202 cycles later. Pulse key_ack -> key_valid = 0.
- Bounce: row 1, col 3 low for 50 cycles, high for 1, then low for 300 -> exactly one report, key_code = 7, latency measured from the final low edge.
- Overflow: accept key 0, then accept key 15 without key_ack -> key_code = 0 and key_overflow = 1. key_ack -> both flags clear.
- Simultaneous events:
  - Columns 0 and 2 low on row 3 -> key_code = 12.
  - key_ack in the accept cycle -> key_valid stays 1 and the new code is shown.
- rst asserted 100 cycles into DEB_PRESS -> no key is reported and the scan restarts at row 0.
